// File: rtl/regfile_if.sv
// Register file access bundle: one write port and two read ports.
// The master drives the write strobe, write data and read indices.
// The slave (the register file) returns the two read values.
interface regfile_if;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  modport master (
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output data_writeReg,
    output ctrl_readRegA,
    output ctrl_readRegB,
    input  data_readRegA,
    input  data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  data_writeReg,
    input  ctrl_readRegA,
    input  ctrl_readRegB,
    output data_readRegA,
    output data_readRegB
  );
endinterface

// File: rtl/regfile.sv
// 32 x 32-bit register file with one write port and two combinational
// read ports. r0 is hard-wired to zero and has no storage. When BYPASS is
// set, a write presented in the current cycle is forwarded to any read port
// that selects the same (non-zero) register. Reset is synchronous and
// active-low, clears every register and suppresses forwarding.
module regfile #(
  parameter int BYPASS = 1
) (
  input logic      clock,
  input logic      reset,
  regfile_if.slave bus
);

  localparam logic C_BYPASS_EN = (BYPASS != 0);

  // Storage for r1..r31; r0 is a constant and never stored.
  logic [31:0] r_regs [1:31];

  logic [31:1] w_wr_en;
  logic [31:0] w_stored [0:31];
  logic        w_bypass_a;
  logic        w_bypass_b;

  // One-hot write decode gated by the write strobe; index 0 has no enable.
  always_comb begin
    w_wr_en = 31'h0000_0000;
    for (int i = 1; i < 32; i++) begin
      w_wr_en[i] = bus.ctrl_writeEnable && (bus.ctrl_writeReg == 5'(i));
    end
  end

  // Register bank: reset clears everything and wins over a concurrent write.
  always_ff @(posedge clock) begin
    for (int i = 1; i < 32; i++) begin
      if (!reset) begin
        r_regs[i] <= 32'h0000_0000;
      end else if (w_wr_en[i]) begin
        r_regs[i] <= bus.data_writeReg;
      end
    end
  end

  // Read view of the array with r0 forced to zero.
  always_comb begin
    w_stored[0] = 32'h0000_0000;
    for (int i = 1; i < 32; i++) begin
      w_stored[i] = r_regs[i];
    end
  end

  // Forwarding is only taken for a live, non-zero write while out of reset.
  assign w_bypass_a = C_BYPASS_EN && reset && bus.ctrl_writeEnable &&
                      (bus.ctrl_writeReg != 5'd0) &&
                      (bus.ctrl_writeReg == bus.ctrl_readRegA);
  assign w_bypass_b = C_BYPASS_EN && reset && bus.ctrl_writeEnable &&
                      (bus.ctrl_writeReg != 5'd0) &&
                      (bus.ctrl_writeReg == bus.ctrl_readRegB);

  // Read port A: forwarded write data or the stored register.
  always_comb begin
    if (w_bypass_a) begin
      bus.data_readRegA = bus.data_writeReg;
    end else begin
      bus.data_readRegA = w_stored[bus.ctrl_readRegA];
    end
  end

  // Read port B: forwarded write data or the stored register.
  always_comb begin
    if (w_bypass_b) begin
      bus.data_readRegB = bus.data_writeReg;
    end else begin
      bus.data_readRegB = w_stored[bus.ctrl_readRegB];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: one instance with forwarding, one without,
// both driven with identical stimulus and checked against hand-computed values.
module tb_regfile;

  logic clock;
  logic reset;

  regfile_if bus1 ();
  regfile_if bus0 ();

  regfile #(.BYPASS(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));
  regfile #(.BYPASS(0)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));

  int err_cnt = 0;
  int chk_cnt = 0;

  // Free-running clock, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Apply the same bus values to both instances, then let combinational reads settle.
  task automatic set_bus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
    bus1.ctrl_writeEnable = we;  bus0.ctrl_writeEnable = we;
    bus1.ctrl_writeReg    = wr;  bus0.ctrl_writeReg    = wr;
    bus1.data_writeReg    = wd;  bus0.data_writeReg    = wd;
    bus1.ctrl_readRegA    = ra;  bus0.ctrl_readRegA    = ra;
    bus1.ctrl_readRegB    = rb;  bus0.ctrl_readRegB    = rb;
    #1;
  endtask

  // Advance past the next rising edge and sample away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] v;

    reset = 1'b0;
    set_bus(1'b0, 5'd0, 32'h0000_0000, 5'd0, 5'd0);
    tick();
    tick();

    // Reset held: a write is neither forwarded nor stored.
    set_bus(1'b1, 5'd5, 32'hCAFE_F00D, 5'd5, 5'd5);
    check_eq("rst_nobyp_a1", bus1.data_readRegA, 32'h0000_0000);
    check_eq("rst_nobyp_b1", bus1.data_readRegB, 32'h0000_0000);
    tick();
    reset = 1'b1;
    set_bus(1'b0, 5'd0, 32'h0000_0000, 5'd5, 5'd5);
    check_eq("rst_prio_a1", bus1.data_readRegA, 32'h0000_0000);
    check_eq("rst_prio_a0", bus0.data_readRegA, 32'h0000_0000);

    // Every index reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      set_bus(1'b0, 5'd0, 32'h0000_0000, 5'(i), 5'(31 - i));
      check_eq("rst_all_a1", bus1.data_readRegA, 32'h0000_0000);
      check_eq("rst_all_b1", bus1.data_readRegB, 32'h0000_0000);
      check_eq("rst_all_a0", bus0.data_readRegA, 32'h0000_0000);
      check_eq("rst_all_b0", bus0.data_readRegB, 32'h0000_0000);
    end

    // Basic write then read on both ports; neighbour unaffected.
    set_bus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd4, 5'd4);
    tick();
    set_bus(1'b0, 5'd0, 32'h0000_0000, 5'd5, 5'd5);
    check_eq("wr5_a1", bus1.data_readRegA, 32'hDEAD_BEEF);
    check_eq("wr5_b1", bus1.data_readRegB, 32'hDEAD_BEEF);
    check_eq("wr5_a0", bus0.data_readRegA, 32'hDEAD_BEEF);
    check_eq("wr5_b0", bus0.data_readRegB, 32'hDEAD_BEEF);
    set_bus(1'b0, 5'd0, 32'h0000_0000, 5'd4, 5'd5);
    check_eq("rd4_a1", bus1.data_readRegA, 32'h0000_0000);
    check_eq("rd4_a0", bus0.data_readRegA, 32'h0000_0000);

    // Writes to r0 are discarded and never forwarded.
    set_bus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    check_eq("r0_same_a1", bus1.data_readRegA, 32'h0000_0000);
    check_eq("r0_same_a0", bus0.data_readRegA, 32'h0000_0000);
    tick();
    set_bus(1'b0, 5'd0, 32'h0000_0000, 5'd0, 5'd0);
    check_eq("r0_next_a1", bus1.data_readRegA, 32'h0000_0000);
    check_eq("r0_next_a0", bus0.data_readRegA, 32'h0000_0000);

    // Forwarding: r7 holds 1, overwrite with read on the same cycle.
    set_bus(1'b1, 5'd7, 32'h0000_0001, 5'd0, 5'd0);
    tick();
    set_bus(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7);
    check_eq("byp_a1", bus1.data_readRegA, 32'h1234_5678);
    check_eq("byp_b1", bus1.data_readRegB, 32'h1234_5678);
    check_eq("nobyp_a0", bus0.data_readRegA, 32'h0000_0001);
    check_eq("nobyp_b0", bus0.data_readRegB, 32'h0000_0001);
    set_bus(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd5);
    check_eq("byp_port_a1", bus1.data_readRegA, 32'h1234_5678);
    check_eq("byp_port_b1", bus1.data_readRegB, 32'hDEAD_BEEF);
    tick();
    set_bus(1'b0, 5'd0, 32'h0000_0000, 5'd7, 5'd7);
    check_eq("after_a1", bus1.data_readRegA, 32'h1234_5678);
    check_eq("after_a0", bus0.data_readRegA, 32'h1234_5678);

    // Reset with concurrent write: reset wins.
    set_bus(1'b1, 5'd31, 32'hA5A5_A5A5, 5'd0, 5'd0);
    tick();
    set_bus(1'b0, 5'd0, 32'h0000_0000, 5'd31, 5'd31);
    check_eq("r31_a1", bus1.data_readRegA, 32'hA5A5_A5A5);
    check_eq("r31_a0", bus0.data_readRegA, 32'hA5A5_A5A5);
    reset = 1'b0;
    set_bus(1'b1, 5'd31, 32'h5A5A_5A5A, 5'd31, 5'd31);
    check_eq("rst_pre_a1", bus1.data_readRegA, 32'hA5A5_A5A5);
    tick();
    check_eq("rst_post_a1", bus1.data_readRegA, 32'h0000_0000);
    check_eq("rst_post_b1", bus1.data_readRegB, 32'h0000_0000);
    check_eq("rst_post_a0", bus0.data_readRegA, 32'h0000_0000);
    set_bus(1'b0, 5'd0, 32'h0000_0000, 5'd7, 5'd5);
    check_eq("rst_clr7_a1", bus1.data_readRegA, 32'h0000_0000);
    check_eq("rst_clr5_b0", bus0.data_readRegB, 32'h0000_0000);

    // First edge with reset released accepts a write.
    reset = 1'b1;
    set_bus(1'b1, 5'd2, 32'h2222_2222, 5'd0, 5'd0);
    tick();
    set_bus(1'b0, 5'd0, 32'h0000_0000, 5'd2, 5'd2);
    check_eq("first_wr_a1", bus1.data_readRegA, 32'h2222_2222);
    check_eq("first_wr_b0", bus0.data_readRegB, 32'h2222_2222);

    // Walk: ri = i * 0x01010101, then a disabled write to r3.
    for (int i = 1; i < 32; i++) begin
      v = 32'(i) * 32'h0101_0101;
      set_bus(1'b1, 5'(i), v, 5'd0, 5'd0);
      tick();
    end
    set_bus(1'b0, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd3);
    check_eq("we0_same_a1", bus1.data_readRegA, 32'h0303_0303);
    tick();
    set_bus(1'b0, 5'd0, 32'h0000_0000, 5'd3, 5'd3);
    check_eq("we0_r3_a1", bus1.data_readRegA, 32'h0303_0303);
    check_eq("we0_r3_a0", bus0.data_readRegA, 32'h0303_0303);
    for (int i = 1; i < 32; i++) begin
      v = 32'(i) * 32'h0101_0101;
      set_bus(1'b0, 5'd0, 32'h0000_0000, 5'(i), 5'(32 - i));
      check_eq("walk_a1", bus1.data_readRegA, v);
      check_eq("walk_a0", bus0.data_readRegA, v);
      v = 32'(32 - i) * 32'h0101_0101;
      check_eq("walk_b1", bus1.data_readRegB, v);
      check_eq("walk_b0", bus0.data_readRegB, v);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
